fetch_decode_buffer: RTL and testbench
======================================

Name: fetch_decode_buffer

Overview:
- IF/ID boundary stage between the fetch PC register and the decode stage.
- Tracks the address in flight to the synchronous instruction memory (1-cycle read latency) and pairs each returned word with its PC+4.
- Presents the word and its PC+4 to decode with a valid flag; handles decode stall via a 1-entry skid buffer and a fetch hold, and handles flush via NOP bubbles.
- Also forms the J-type jump target fed back to fetch's jump_exe path.

Parameters:
- DATA_W, 32, instruction/address width (fixed 32 by the datapath).
- NOP_WORD, 32'h0000_0000, word driven on instr_id when the stage holds a bubble.

Ports:
- reloj  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  32  PC presented to instruction memory this cycle (fetch OUT_REG1).
- pc4_hi  in  4  PC+4[31:28] from fetch, aligned with pc_in.
- instr_mem  in  32  instruction memory data; valid the cycle after its address.
- stall_id  in  1  decode cannot accept; hold outputs.
- flush  in  1  taken jump/branch; discard everything younger.
- instr_id  out  32  instruction to decode.
- pc4_id  out  32  PC+4 of instr_id.
- jump_target  out  32  {pc4_id[31:28], instr_id[25:0], 2'b00}.
- valid_id  out  1  instr_id/pc4_id hold a real instruction.
- fetch_hold  out  1  request fetch to freeze its PC register.

Behaviour:
- Clock is reloj; reset is synchronous and active-high. All state changes on the rising edge of reloj.
- Reset: valid_id=0, instr_id=NOP_WORD, pc4_id=0, fetch_hold=0, in-flight valid=0, skid empty. Reset wins over all inputs.
- In-flight register: each non-held cycle captures pc_in+4 (full 32-bit, wraps modulo 2^32) and sets inflight_v=1. The next cycle instr_mem belongs to that entry.
- Nominal (no stall, skid empty): instr_mem plus the in-flight PC+4 load the output registers. Latency from pc_in to valid_id is 2 edges; throughput is 1 per cycle.
- Stall (stall_id=1): the output registers hold.
  - If inflight_v, the returning word and PC+4 go to the skid entry (skid_v=1).
  - fetch_hold asserts combinationally whenever skid_v=1, or stall_id=1 with inflight_v=1.
  - While fetch_hold=1, no new in-flight entry is captured; inflight_v clears once consumed.
- Stall release with skid_v=1: the skid entry loads the outputs first, skid_v clears, and fetch_hold drops the same cycle. The in-flight path resumes the following cycle. No word is lost or duplicated.
- Flush: clears valid_id, inflight_v and skid_v. instr_id becomes NOP_WORD, pc4_id holds its value, fetch_hold becomes 0. The next capture starts from the new pc_in.
  - Flush has priority over stall.
  - Flush together with reset: reset applies.
- Stall while valid_id=0 simply holds the bubble.
- Bounds: one skid entry is sufficient because fetch_hold stops issue within 1 cycle. Skid overflow is not reachable; the bench asserts it never occurs.
- jump_target is combinational from the output registers and is meaningful only when valid_id=1.

Optional Feature:
- Macro: FETCH_DECODE_BUFFER_STATS_EN.
- When defined:
  - Adds output ports stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each cycle with stall_id=1 and valid_id=1; flush_cnt increments on each flush.
  - Both saturate at 16'hFFFF and reset to 0.
- When not defined: no counter ports and no counter logic.

Decomposition:
- Shared package (isa_pkg) holds:
  - NOP_WORD, INSTR_W=32, PC_STEP=4.
  - J-type field positions: target [25:0], opcode [31:26].
- One sub-module, ifid_skid_entry: a 1-entry data+valid holding register with load/clear, instantiated once for the skid.

Test Plan:
- Sequential fetch: pc_in 0x0,0x4,0x8 with instr_mem 0x11111111,0x22222222,0x33333333 one cycle later -> valid_id=1 two edges after each PC; pc4_id 0x4,0x8,0xC; matching words in order.
- Stall 3 cycles mid-stream: while stall_id=1, outputs hold 0x22222222, the skid captures 0x33333333, and fetch_hold=1. After release, 0x33333333/pc4_id 0xC appear next cycle; no duplicate, no loss.
- Flush during stall with skid full -> next edge valid_id=0, instr_id=0x00000000, fetch_hold=0, skid empty. The first word after the new pc_in=0x400 appears with pc4_id=0x404.
- Jump target: instr_id=0x08000010 with pc4_id=0x40000008 -> jump_target=0x40000040.
- Reset asserted mid-stall with skid full -> next edge all outputs at reset values. PC wrap: pc_in=0xFFFFFFFC -> pc4_id=0x00000000.
- With FETCH_DECODE_BUFFER_STATS_EN defined: 5 stall cycles and 2 flushes -> stall_cnt=5, flush_cnt=2. Forcing 70000 stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants for the IF/ID boundary: instruction width, PC step,
// the bubble word and J-type field positions.
package isa_pkg;

    localparam int                 INSTR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] PC_STEP  = 32'd4;

    localparam int J_TGT_MSB = 25;
    localparam int J_TGT_LSB = 0;
    localparam int J_OPC_MSB = 31;
    localparam int J_OPC_LSB = 26;

endpackage

// File: rtl/ifid_skid_entry.sv
// One-entry data+valid holding register used as the IF/ID skid slot.
// Priority: reset, then clear, then load.
module ifid_skid_entry
    import isa_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_q
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_data;

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF/ID boundary: pairs synchronous-imem words with PC+4, 1-entry skid on stall,
// NOP bubbles on flush. Optional counters under FETCH_DECODE_BUFFER_STATS_EN.
module fetch_decode_buffer #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        pc4_hi,
    input  logic [DATA_W-1:0] instr_mem,
    input  logic              stall_id,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_id,
    output logic [DATA_W-1:0] pc4_id,
    output logic [DATA_W-1:0] jump_target,
    output logic              valid_id,
    output logic              fetch_hold
`ifdef FETCH_DECODE_BUFFER_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    import isa_pkg::*;

    logic              r_inflight_v;
    logic [DATA_W-1:0] r_inflight_pc4;
    logic              r_valid_id;
    logic [DATA_W-1:0] r_instr_id;
    logic [DATA_W-1:0] r_pc4_id;

    logic                w_fetch_hold;
    logic                w_skid_v;
    logic                w_skid_load;
    logic                w_skid_clear;
    logic [2*DATA_W-1:0] w_skid_q;
    logic                w_unused;

    // Once held, no new address is issued, so the skid can never be refilled while full.
    assign w_fetch_hold = w_skid_v | (stall_id & r_inflight_v);
    assign w_skid_load  = stall_id & r_inflight_v & ~flush;
    assign w_skid_clear = flush | (~stall_id & w_skid_v);

    ifid_skid_entry #(
        .W (2*DATA_W)
    ) u_skid (
        .i_clk   (reloj),
        .i_rst   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     ({instr_mem, r_inflight_pc4}),
        .o_valid (w_skid_v),
        .o_q     (w_skid_q)
    );

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_inflight_v   <= 1'b0;
            r_inflight_pc4 <= '0;
        end else if (flush) begin
            r_inflight_v   <= 1'b0;
        end else if (!w_fetch_hold) begin
            r_inflight_v   <= 1'b1;
            r_inflight_pc4 <= pc_in + PC_STEP;
        end else begin
            r_inflight_v   <= 1'b0;
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_WORD;
            r_pc4_id   <= '0;
        end else if (flush) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP_WORD;
        end else if (!stall_id) begin
            // The skid entry is older than anything in flight, so it drains first.
            if (w_skid_v) begin
                r_valid_id <= 1'b1;
                r_instr_id <= w_skid_q[2*DATA_W-1:DATA_W];
                r_pc4_id   <= w_skid_q[DATA_W-1:0];
            end else if (r_inflight_v) begin
                r_valid_id <= 1'b1;
                r_instr_id <= instr_mem;
                r_pc4_id   <= r_inflight_pc4;
            end else begin
                r_valid_id <= 1'b0;
                r_instr_id <= NOP_WORD;
            end
        end
    end

    assign instr_id    = r_instr_id;
    assign pc4_id      = r_pc4_id;
    assign valid_id    = r_valid_id;
    assign fetch_hold  = w_fetch_hold;
    assign jump_target = {r_pc4_id[31:28], r_instr_id[J_TGT_MSB:J_TGT_LSB], 2'b00};

    // pc4_hi is redundant with the locally formed PC+4; opcode is decoded downstream.
    assign w_unused = ^{pc4_hi, r_instr_id[J_OPC_MSB:J_OPC_LSB]};

`ifdef FETCH_DECODE_BUFFER_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_id && r_valid_id && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer; counter tests build only with
// FETCH_DECODE_BUFFER_STATS_EN defined.
module tb_fetch_decode_buffer;

    logic        reloj = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [3:0]  pc4_hi;
    logic [31:0] instr_mem;
    logic        stall_id;
    logic        flush;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic [31:0] jump_target;
    logic        valid_id;
    logic        fetch_hold;
`ifdef FETCH_DECODE_BUFFER_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int overflow_cnt = 0;
    logic [64:0] got;
    logic [64:0] exp;

    fetch_decode_buffer dut (
        .reloj       (reloj),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc4_hi      (pc4_hi),
        .instr_mem   (instr_mem),
        .stall_id    (stall_id),
        .flush       (flush),
        .instr_id    (instr_id),
        .pc4_id      (pc4_id),
        .jump_target (jump_target),
        .valid_id    (valid_id),
        .fetch_hold  (fetch_hold)
`ifdef FETCH_DECODE_BUFFER_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 reloj = ~reloj;

    always @(negedge reloj) begin
        if (!reset && dut.w_skid_load && dut.w_skid_v)
            overflow_cnt++;
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] mem,
                         input logic st, input logic fl);
        logic [31:0] p4;
        p4        = pc + 32'd4;
        pc_in     = pc;
        pc4_hi    = p4[31:28];
        instr_mem = mem;
        stall_id  = st;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic prime_stream();
        drive(32'h0, 32'h0, 1'b0, 1'b0);        tick();
        drive(32'h4, 32'h11111111, 1'b0, 1'b0); tick();
        drive(32'h8, 32'h22222222, 1'b0, 1'b0); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'h1234, 32'hFFFFFFFF, 1'b1, 1'b1);
        tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b0, 32'h0, 32'h0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", got, exp);
        end
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got %b expected 0", fetch_hold);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs [4];
        logic [31:0] words [4];
        pcs   = '{32'h4, 32'h8, 32'hC, 32'h10};
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        do_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid_id !== 1'b0 || instr_id !== 32'h0) begin
            failures++;
            $display("FAIL seq_first_bubble: got v=%b i=%h expected v=0 i=00000000", valid_id, instr_id);
        end
        for (int i = 0; i < 4; i++) begin
            drive(pcs[i], words[i], 1'b0, 1'b0);
            tick();
            got = {valid_id, instr_id, pc4_id}; exp = {1'b1, words[i], pcs[i]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL seq_word%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] junk [3];
        junk = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
        do_reset();
        prime_stream();
        checks++;
        if (instr_id !== 32'h22222222 || pc4_id !== 32'h8) begin
            failures++;
            $display("FAIL stall_prime: got i=%h p=%h expected i=22222222 p=8", instr_id, pc4_id);
        end
        drive(32'hC, 32'h33333333, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fetch_hold !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d: got %b expected 1", i, fetch_hold);
            end
            tick();
            got = {valid_id, instr_id, pc4_id}; exp = {1'b1, 32'h22222222, 32'h8};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall_outputs%0d: got %h expected %h", i, got, exp);
            end
            drive(32'hC, junk[i], 1'b1, 1'b0);
        end
        drive(32'hC, 32'hDEAD0004, 1'b0, 1'b0);
        #1;
        checks++;
        if (fetch_hold !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_hold: got %b expected 1", fetch_hold);
        end
        tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b1, 32'h33333333, 32'hC};
        checks++;
        if (got !== exp || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL stall_skid_drain: got %h hold=%b expected %h hold=0", got, fetch_hold, exp);
        end
        drive(32'hC, 32'hDEAD0005, 1'b0, 1'b0);
        tick();
        checks++;
        if (valid_id !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_dup: got v=%b i=%h expected v=0", valid_id, instr_id);
        end
        drive(32'h10, 32'h44444444, 1'b0, 1'b0);
        tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b1, 32'h44444444, 32'h10};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL stall_resume: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_flush();
        do_reset();
        prime_stream();
        drive(32'hC, 32'h33333333, 1'b1, 1'b0); tick();
        drive(32'hC, 32'hDEAD0001, 1'b1, 1'b0); tick();
        drive(32'hC, 32'hDEAD0002, 1'b1, 1'b1); tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b0, 32'h0, 32'h8};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush_outputs: got %h expected %h", got, exp);
        end
        drive(32'h400, 32'hDEAD0003, 1'b0, 1'b0);
        #1;
        checks++;
        if (fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold: got %b expected 0", fetch_hold);
        end
        tick();
        checks++;
        if (valid_id !== 1'b0) begin
            failures++;
            $display("FAIL flush_skid_empty: got v=%b i=%h expected v=0", valid_id, instr_id);
        end
        drive(32'h404, 32'hAAAA5555, 1'b0, 1'b0);
        tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b1, 32'hAAAA5555, 32'h404};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush_restart: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_jump_target();
        do_reset();
        drive(32'h40000004, 32'h0, 1'b0, 1'b0);        tick();
        drive(32'h40000008, 32'h08000010, 1'b0, 1'b0); tick();
        checks++;
        if (jump_target !== 32'h40000040 || pc4_id !== 32'h40000008) begin
            failures++;
            $display("FAIL jump_target: got jt=%h p=%h expected jt=40000040 p=40000008", jump_target, pc4_id);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        prime_stream();
        drive(32'hC, 32'h33333333, 1'b1, 1'b0); tick();
        reset = 1'b1;
        drive(32'hC, 32'hDEAD0001, 1'b1, 1'b0);
        tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b0, 32'h0, 32'h0};
        checks++;
        if (got !== exp || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stall: got %h hold=%b expected %h hold=0", got, fetch_hold, exp);
        end
        reset = 1'b0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        drive(32'hFFFFFFFC, 32'h0, 1'b0, 1'b0);    tick();
        drive(32'h0, 32'h12345678, 1'b0, 1'b0);    tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b1, 32'h12345678, 32'h0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL pc_wrap: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_stall_bubble();
        do_reset();
        drive(32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if (fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL bubble_hold_idle: got %b expected 0", fetch_hold);
        end
        tick();
        drive(32'h4, 32'h11111111, 1'b1, 1'b0);
        #1;
        checks++;
        if (fetch_hold !== 1'b1) begin
            failures++;
            $display("FAIL bubble_hold_inflight: got %b expected 1", fetch_hold);
        end
        tick();
        checks++;
        if (valid_id !== 1'b0 || instr_id !== 32'h0) begin
            failures++;
            $display("FAIL bubble_held: got v=%b i=%h expected v=0 i=00000000", valid_id, instr_id);
        end
        drive(32'h4, 32'hDEAD0001, 1'b0, 1'b0);
        tick();
        got = {valid_id, instr_id, pc4_id}; exp = {1'b1, 32'h11111111, 32'h4};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL bubble_release: got %h expected %h", got, exp);
        end
    endtask

`ifdef FETCH_DECODE_BUFFER_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            failures++;
            $display("FAIL stats_reset: got s=%h f=%h expected 0 0", stall_cnt, flush_cnt);
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);        tick();
        drive(32'h4, 32'h11111111, 1'b0, 1'b0); tick();
        drive(32'h8, 32'h22222222, 1'b1, 1'b0);
        repeat (5) tick();
        drive(32'h8, 32'h0, 1'b0, 1'b1); tick();
        drive(32'h8, 32'h0, 1'b0, 1'b1); tick();
        checks++;
        if (stall_cnt !== 16'd5 || flush_cnt !== 16'd2) begin
            failures++;
            $display("FAIL stats_counts: got s=%0d f=%0d expected s=5 f=2", stall_cnt, flush_cnt);
        end
        do_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0);        tick();
        drive(32'h4, 32'h11111111, 1'b0, 1'b0); tick();
        drive(32'h8, 32'h22222222, 1'b1, 1'b0);
        repeat (70000) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_saturate: got s=%h expected ffff", stall_cnt);
        end
        drive(32'h8, 32'h0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_no_overflow();
        checks++;
        if (overflow_cnt !== 0) begin
            failures++;
            $display("FAIL skid_overflow: got %0d events expected 0", overflow_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_jump_target();
        test_reset_mid_stall();
        test_pc_wrap();
        test_stall_bubble();
`ifdef FETCH_DECODE_BUFFER_STATS_EN
        test_stats();
`endif
        test_no_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
